sc_stream_sequencer: RTL and testbench

//  Sequences one evaluation of a combinational stochastic-computing core (select x, random bits r, stream bit z).
//  On start: latches the select code, drives the core with fresh LFSR random bits for 2^LEN_LOG2 cycles,

---
 rtl/sc_pkg.sv | 16 +
 rtl/sc_lfsr.sv | 43 ++++
 rtl/sc_stream_sequencer.sv | 109 ++++++++++
 tb/tb_sc_stream_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and constants for stochastic-computing control blocks.
// Holds the sequencer state encoding and the default 16-bit LFSR polynomial and seed.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          LFSR_W       = 16;
  // x^16 + x^14 + x^13 + x^11 + 1, expressed as the bits XORed into the new bit 0.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR, shift-left, feedback = XOR of tapped bits; load reseeds, en advances, else holds.
// One-cycle update latency; an all-zero state reloads SEED on the next edge so the generator never locks up.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int          W     = LFSR_W,
  parameter logic [W-1:0] TAPS = LFSR_TAPS,
  parameter logic [W-1:0] SEED = DEFAULT_SEED,
  parameter int          OUT_W = W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [OUT_W-1:0] q
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic         fb;

  assign fb = ^(state_q & TAPS);

  always_comb begin
    state_d = state_q;
    if (load || (state_q == '0)) begin
      state_d = SEED;
    end else if (en) begin
      state_d = {state_q[W-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q[OUT_W-1:0];

endmodule

// File: rtl/sc_stream_sequencer.sv
// Runs one 2^LEN_LOG2-cycle stochastic evaluation: latch select, feed LFSR bits, count ones on z, report count.
// done pulses N+1 cycles after start is sampled; start is ignored outside IDLE, abort cancels a run without done.
module sc_stream_sequencer
  import sc_pkg::*;
#(
  parameter int          SEL_W    = 3,
  parameter int          RAND_W   = 6,
  parameter int          LEN_LOG2 = 8,
  parameter logic [15:0] SEED     = DEFAULT_SEED
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SEL_W-1:0]    x_in,
  input  logic                z_in,
  output logic [SEL_W-1:0]    sel_out,
  output logic [RAND_W-1:0]   rnd_out,
  output logic                busy,
  output logic                done,
  output logic [LEN_LOG2:0]   result
);

  localparam logic [LEN_LOG2-1:0] CYC_LAST = '1;

  state_t              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic [LEN_LOG2:0]   ones_q;
  logic [LEN_LOG2:0]   ones_d;
  logic [LEN_LOG2-1:0] cyc_q;
  logic [LEN_LOG2:0]   result_q;
  logic                busy_q;
  logic                done_q;
  logic                lfsr_load;
  logic                lfsr_en;

  assign lfsr_load = (state_q == IDLE) && start;
  assign lfsr_en   = (state_q == RUN);
  // The final-edge sample is folded in here so result includes all N bits.
  assign ones_d    = ones_q + {{LEN_LOG2{1'b0}}, z_in};

  sc_lfsr #(
    .W     (LFSR_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED),
    .OUT_W (RAND_W)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .q     (rnd_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ones_q   <= '0;
      cyc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sel_q   <= x_in;
            ones_q  <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ones_q <= ones_d;
            cyc_q  <= cyc_q + LEN_LOG2'(1);
            if (cyc_q == CYC_LAST) begin
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= ones_d;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sel_out = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_sc_stream_sequencer.sv
// Bench for sc_stream_sequencer: a N=256 instance and a N=4 instance, results checked through scoreboards.
`timescale 1ns/1ps
module tb_sc_stream_sequencer;

  logic clk;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- instance A: LEN_LOG2 = 8 ----------------
  logic       a_rst_n, a_start, a_abort, a_z;
  logic [2:0] a_x, a_sel;
  logic [5:0] a_rnd;
  logic       a_busy, a_done;
  logic [8:0] a_result;
  int         a_zmode = 0;

  assign a_z = (a_zmode == 2) ? a_rnd[0] : (a_zmode == 1);

  sc_stream_sequencer #(.SEL_W(3), .RAND_W(6), .LEN_LOG2(8), .SEED(16'hACE1)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n), .start(a_start), .abort(a_abort), .x_in(a_x), .z_in(a_z),
    .sel_out(a_sel), .rnd_out(a_rnd), .busy(a_busy), .done(a_done), .result(a_result)
  );

  // ---------------- instance B: LEN_LOG2 = 2 ----------------
  logic       b_rst_n, b_start, b_abort;
  logic [2:0] b_sel;
  logic [5:0] b_rnd;
  logic       b_busy, b_done;
  logic [2:0] b_result;

  sc_stream_sequencer #(.SEL_W(3), .RAND_W(6), .LEN_LOG2(2), .SEED(16'hACE1)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .abort(b_abort), .x_in(3'd1), .z_in(1'b1),
    .sel_out(b_sel), .rnd_out(b_rnd), .busy(b_busy), .done(b_done), .result(b_result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Scoreboards: expected results queued at start, consumed on each done pulse.
  int a_q[$];
  int b_q[$];
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int a_last_t = 0;
  int b_times[$];

  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      a_done_cnt++;
      a_last_t = cyc_cnt;
      if (a_q.size() == 0) chk("a_unexpected_done", 1, 0);
      else chk("a_result", a_result, a_q.pop_front());
    end
    if (b_done === 1'b1) begin
      b_done_cnt++;
      b_times.push_back(cyc_cnt);
      if (b_q.size() == 0) chk("b_unexpected_done", 1, 0);
      else chk("b_result", b_result, b_q.pop_front());
    end
  end

  function automatic int ref_pop(input int n);
    logic [15:0] s;
    int          cnt;
    s = 16'hACE1;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cnt += int'(s[0]);
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
    return cnt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_go(input logic [2:0] x);
    a_x = x;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_wait_done(input int budget);
    int n0;
    int i;
    n0 = a_done_cnt;
    i = 0;
    while (a_done_cnt == n0 && i < budget) begin
      tick();
      i++;
    end
    chk("a_done_in_time", a_done_cnt != n0, 1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n0, bad, pop;
    a_rst_n = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_x = 3'd0;
    b_rst_n = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    pop = ref_pop(256);
    tick(); tick();
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_result", a_result, 0);
    chk("rst_sel", a_sel, 0);
    chk("rst_rnd", a_rnd, 6'h21);
    chk("rst_b_result", b_result, 0);

    // z tied high, cycle-exact window check
    a_zmode = 1;
    a_q.push_back(256);
    a_x = 3'd5;
    a_start = 1'b1;
    t0 = cyc_cnt;
    tick();
    a_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (!(a_busy === 1'b1 && a_done === 1'b0 && a_sel === 3'd5)) bad++;
      tick();
    end
    chk("run_window", bad, 0);
    chk("done_pulse", a_done, 1);
    chk("busy_after", a_busy, 0);
    chk("latency", cyc_cnt - t0, 257);
    tick();
    chk("done_one_cycle", a_done, 0);
    chk("result_hold", a_result, 256);

    // z tied low, then LFSR-bit0 stream twice (reseeded each start)
    a_zmode = 0; a_q.push_back(0);   a_go(3'd5); a_wait_done(300);
    a_zmode = 2; a_q.push_back(pop); a_go(3'd5); a_wait_done(300);
    a_q.push_back(pop);              a_go(3'd5); a_wait_done(300);

    // start and x_in wiggled during RUN
    a_zmode = 1;
    a_q.push_back(256);
    a_go(3'd2);
    n0 = a_done_cnt;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      a_x = i[2:0];
      a_start = (i % 3 == 0);
      if (a_sel !== 3'd2) bad++;
      tick();
    end
    a_start = 1'b0;
    a_wait_done(100);
    chk("sel_latched", bad, 0);
    repeat (20) tick();
    chk("done_once", a_done_cnt - n0, 1);

    // abort at cycle 100
    a_zmode = 0;
    a_go(3'd3);
    repeat (99) tick();
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_result", a_result, 256);
    n0 = a_done_cnt;
    repeat (300) tick();
    chk("abort_no_done", a_done_cnt - n0, 0);
    a_zmode = 2; a_q.push_back(pop); a_go(3'd4); a_wait_done(300);

    // abort on the final-count edge wins
    a_zmode = 1;
    a_go(3'd1);
    repeat (255) tick();
    a_abort = 1'b1;
    n0 = a_done_cnt;
    tick();
    a_abort = 1'b0;
    chk("abort_last_busy", a_busy, 0);
    chk("abort_last_done", a_done, 0);
    repeat (5) tick();
    chk("abort_last_nodone", a_done_cnt - n0, 0);
    chk("abort_last_result", a_result, pop);

    // reset mid-run
    a_go(3'd6);
    repeat (49) tick();
    a_rst_n = 1'b0;
    tick();
    chk("mrst_busy", a_busy, 0);
    chk("mrst_done", a_done, 0);
    chk("mrst_result", a_result, 0);
    chk("mrst_sel", a_sel, 0);
    chk("mrst_rnd", a_rnd, 6'h21);
    a_rst_n = 1'b1;
    n0 = a_done_cnt;
    repeat (300) tick();
    chk("mrst_no_done", a_done_cnt - n0, 0);

    // N=4 instance: latency, back-to-back, start+abort in IDLE
    b_q.push_back(4);
    t0 = cyc_cnt;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 20 && b_done_cnt == 0; i++) tick();
    chk("b_done_seen", b_done_cnt, 1);
    if (b_times.size() > 0) chk("b_latency", b_times[0] - t0, 5);
    repeat (3) tick();

    b_q.push_back(4); b_q.push_back(4);
    n0 = b_done_cnt;
    b_start = 1'b1;
    repeat (7) tick();
    b_start = 1'b0;
    for (int i = 0; i < 30 && b_done_cnt < n0 + 2; i++) tick();
    repeat (10) tick();
    chk("b2b_count", b_done_cnt - n0, 2);
    if (b_times.size() >= n0 + 2) chk("b2b_spacing", b_times[n0+1] - b_times[n0], 6);

    b_q.push_back(4);
    n0 = b_done_cnt;
    b_start = 1'b1; b_abort = 1'b1;
    tick();
    b_start = 1'b0; b_abort = 1'b0;
    chk("b_start_abort_busy", b_busy, 1);
    repeat (10) tick();
    chk("b_start_abort_done", b_done_cnt - n0, 1);

    chk("a_sb_empty", a_q.size(), 0);
    chk("b_sb_empty", b_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
